// File: rtl/dm_responder.sv
// dm_responder: memory-side end of the MEM-stage load/store interface.
// Accepts one word-addressed request at a time over req/ack and applies
// byte-enabled stores or full-word loads after a fixed LATENCY.
// Optional feature: define DM_WRITE_LOG_EN to print one log line for every
// committed in-range store with non-zero byte enables.
module dm_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;

    logic        we_q;
    logic [3:0]  be_q;
    logic [29:0] waddr_q;
    logic [31:0] wdata_q;

    // Storage array has no reset; a per-word valid vector stands in for
    // the reset-time clear, so a word never written since reset reads 0.
    logic [31:0]            mem [DEPTH_WORDS];
    logic [DEPTH_WORDS-1:0] word_valid;

    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             access;
    logic             commit;
    logic [31:0]      cur_word;
    logic [31:0]      merged_word;

    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    assign idx      = waddr_q[IDX_W-1:0];
    assign in_range = (waddr_q < DEPTH_LIM);
    assign access   = (state == WAIT) && (cnt == 4'd0);
    assign commit   = access && in_range && we_q && (be_q != 4'b0000);
    assign busy     = (state != IDLE);

    // Current word contents and the word after applying the byte enables
    always_comb begin
        cur_word    = word_valid[idx] ? mem[idx] : 32'h0;
        merged_word = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
                merged_word[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> WAIT on req, WAIT -> RESP when count expires, RESP lasts one cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = WAIT;
            WAIT:    if (cnt == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latching, latency countdown and response generation
    always_ff @(posedge clk) begin
        if (reset) begin
            ack        <= 1'b0;
            err        <= 1'b0;
            rdata      <= 32'h0;
            cnt        <= 4'd0;
            word_valid <= '0;
        end else begin
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= 32'h0;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        be_q    <= be;
                        waddr_q <= addr[31:2];
                        wdata_q <= wdata;
                        cnt     <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        ack <= 1'b1;
                        if (!in_range) begin
                            err <= 1'b1;
                        end else if (we_q) begin
                            if (be_q != 4'b0000) begin
                                word_valid[idx] <= 1'b1;
                            end
                        end else begin
                            rdata <= cur_word;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Store commit into the word array
    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            mem[idx] <= merged_word;
        end
    end

`ifdef DM_WRITE_LOG_EN
    logic [31:0] pc_q;

    // Capture the requesting PC alongside the other request fields
    always_ff @(posedge clk) begin
        if (!reset && (state == IDLE) && req) begin
            pc_q <= pc;
        end
    end

    // Log each committed store with its post-write word value
    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            $display("%d@%h: *%h <= %h", $time, pc_q, {waddr_q, 2'b00}, merged_word);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: scoreboard bench for dm_responder with a word-array
// reference model; directed cases followed by randomized requests.
module tb_dm_responder;

    localparam int DEPTH = 4096;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        ack;
    logic [31:0] rdata;
    logic        err;
    logic        busy;

    dm_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .we   (we),
        .be   (be),
        .addr (addr),
        .wdata(wdata),
        .pc   (pc),
        .ack  (ack),
        .rdata(rdata),
        .err  (err),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] model [DEPTH];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic void clearModel();
        foreach (model[i]) model[i] = 32'h0;
    endfunction

    // Monitor: every ack must match the oldest expected response
    always @(negedge clk) begin
        if (reset === 1'b0 && ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_ack: got ack=1 (rdata %h) expected no response", rdata);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("rdata", rdata, mon_e.rdata);
                checkOutput("err", 32'(err), 32'(mon_e.err));
                checkOutput("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    // Issue one request; poke pulses a stray req during WAIT, abort resets during WAIT
    task automatic applyStimulus(input logic we_i, input logic [3:0] be_i,
                                 input logic [31:0] addr_i, input logic [31:0] wdata_i,
                                 input bit poke, input bit abort);
        exp_t        ex;
        int          acc;
        bit          done;
        logic [29:0] widx;
        @(negedge clk);
        req   = 1'b1;
        we    = we_i;
        be    = be_i;
        addr  = addr_i;
        wdata = wdata_i;
        pc    = $urandom;
        @(posedge clk);
        #1;
        acc   = cyc;
        req   = 1'b0;
        we    = 1'($urandom);
        be    = 4'($urandom);
        addr  = $urandom;
        wdata = $urandom;
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        if (abort) begin
            @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            @(posedge clk);
            #1;
            reset = 1'b0;
            clearModel();
            checkOutput("busy_after_reset", 32'(busy), 32'd0);
            return;
        end
        widx   = addr_i[31:2];
        ex.cyc = acc + LAT;
        if (widx >= 30'(DEPTH)) begin
            ex.rdata = 32'h0;
            ex.err   = 1'b1;
        end else if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) model[int'(widx)][8*i +: 8] = wdata_i[8*i +: 8];
            end
            ex.rdata = 32'h0;
            ex.err   = 1'b0;
        end else begin
            ex.rdata = model[int'(widx)];
            ex.err   = 1'b0;
        end
        exp_q.push_back(ex);
        done = 1'b0;
        for (int n = 0; n < LAT + 4; n++) begin
            @(negedge clk);
            if (poke && n == 0) begin
                req  = 1'b1;
                we   = 1'b0;
                addr = 32'h20;
            end
            if (poke && n == 1) req = 1'b0;
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL busy_timeout: got busy=1 after %0d cycles expected idle", LAT + 4);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          r;
        reset = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        be    = 4'h0;
        addr  = 32'h0;
        wdata = 32'h0;
        pc    = 32'h0;
        clearModel();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_ack", 32'(ack), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_rdata", rdata, 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'd0);

        $display("[TB] directed cases");
        applyStimulus(1'b0, 4'h0, 32'h0000_0000, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 32'h0000_0010, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b0010, 32'h0000_0010, 32'h0000_AA00, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 32'h0000_0010, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b0000, 32'h0000_0010, 32'h1234_5678, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 32'h0000_0010, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 32'(DEPTH * 4), 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hF, 32'(DEPTH * 4), 32'hCAFE_F00D, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 32'h0000_0000, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 32'h0000_0013, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hF, 32'(DEPTH * 4 - 4), 32'h1234_5678, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 32'(DEPTH * 4 - 4), 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 32'h0000_0010, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'hF, 32'h0000_0020, 32'h55AA_55AA, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'h0, 32'h0000_0020, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 32'h0000_0010, 32'h0, 1'b0, 1'b0);

        $display("[TB] randomized requests");
        repeat (200) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                a = $urandom | 32'h0001_0000;
            end else if (r == 1) begin
                a = 32'(DEPTH * 4 - 4) - 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            end else begin
                a = 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            end
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), a, $urandom, 1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        checkOutput("pending_responses", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
